// File: rtl/compl1_deser_dec_if.sv
`default_nettype none
// ============================================================================
// Module      : compl1_deser_dec_if
// Description : Bundle of the serial-in / result-out signals of
//               compl1_deser_dec.
//               master : frame source and result consumer
//                        (drives start, cpl_in, sin, sin_valid, out_ready).
//               slave  : the deserialiser/decoder
//                        (drives busy, out_valid, data_out, sign_out,
//                        mag_out, negzero_out).
// Revision    : 1.0 - initial release
// ============================================================================
interface compl1_deser_dec_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             cpl_in;
    logic             sin;
    logic             sin_valid;
    logic             out_ready;
    logic             busy;
    logic             out_valid;
    logic [WIDTH-1:0] data_out;
    logic             sign_out;
    logic [WIDTH-2:0] mag_out;
    logic             negzero_out;

    modport master (
        output start, cpl_in, sin, sin_valid, out_ready,
        input  busy, out_valid, data_out, sign_out, mag_out, negzero_out
    );

    modport slave (
        input  start, cpl_in, sin, sin_valid, out_ready,
        output busy, out_valid, data_out, sign_out, mag_out, negzero_out
    );
endinterface
`default_nettype wire

// File: rtl/compl1_deser_dec.sv
`default_nettype none
// ============================================================================
// Module      : compl1_deser_dec
// Description : Serial (LSB-first) receiver for words coded by the
//               ones'-complement stage. Undoes the conditional inversion
//               selected by the frame's cpl flag and decodes the restored
//               word as a signed ones'-complement number.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               bus (slave)   - start/cpl_in/sin/sin_valid in,
//                               out_ready in, busy/out_valid out,
//                               data_out/sign_out/mag_out/negzero_out out
// Options     : COMPL1_NEGZERO_FIX_EN - when defined, negative zero
//               (all ones) is reported as +0 with negzero_out still set.
// Revision    : 1.0 - initial release
// ============================================================================
module compl1_deser_dec #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    compl1_deser_dec_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [WIDTH-1:0]   sreg_q,    sreg_d;
    logic               cpl_q,     cpl_d;
    logic               busy_q,    busy_d;
    logic               valid_q,   valid_d;
    logic [WIDTH-1:0]   data_q,    data_d;
    logic               sign_q,    sign_d;
    logic [WIDTH-2:0]   mag_q,     mag_d;
    logic               negzero_q, negzero_d;

    // Shift register contents once the current bit is taken in.
    logic [WIDTH-1:0]   w_shifted;
    logic [WIDTH-1:0]   w_restored;
    logic               w_negzero;
    logic [WIDTH-1:0]   w_data;
    logic               w_sign;
    logic [WIDTH-2:0]   w_mag;

    assign w_shifted = {bus.sin, sreg_q[WIDTH-1:1]};

    // Decode of the word that would be complete after this edge.
    always_comb begin
        w_restored = w_shifted ^ {WIDTH{cpl_q}};
        w_negzero  = &w_restored;
`ifdef COMPL1_NEGZERO_FIX_EN
        w_data     = w_negzero ? '0 : w_restored;
`else
        w_data     = w_restored;
`endif
        w_sign     = w_data[WIDTH-1];
        w_mag      = w_sign ? ~w_data[WIDTH-2:0] : w_data[WIDTH-2:0];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sreg_d    = sreg_q;
        cpl_d     = cpl_q;
        busy_d    = busy_q;
        valid_d   = valid_q;
        data_d    = data_q;
        sign_d    = sign_q;
        mag_d     = mag_q;
        negzero_d = negzero_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    cpl_d   = bus.cpl_in;
                    cnt_d   = '0;
                    sreg_d  = '0;
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bus.sin_valid) begin
                    sreg_d = w_shifted;
                    cnt_d  = cnt_q + 1'b1;
                    // Last bit: result registers load on the same edge.
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d   = S_DONE;
                        valid_d   = 1'b1;
                        data_d    = w_data;
                        sign_d    = w_sign;
                        mag_d     = w_mag;
                        negzero_d = w_negzero;
                    end
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sreg_q    <= '0;
            cpl_q     <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            sign_q    <= 1'b0;
            mag_q     <= '0;
            negzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sreg_q    <= sreg_d;
            cpl_q     <= cpl_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            sign_q    <= sign_d;
            mag_q     <= mag_d;
            negzero_q <= negzero_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.out_valid   = valid_q;
    assign bus.data_out    = data_q;
    assign bus.sign_out    = sign_q;
    assign bus.mag_out     = mag_q;
    assign bus.negzero_out = negzero_q;

endmodule
`default_nettype wire

// File: tb/tb_compl1_deser_dec.sv
`default_nettype none
// ============================================================================
// Module      : tb_compl1_deser_dec
// Description : Self-checking bench for compl1_deser_dec (WIDTH=4).
//               Table of frames {cpl, received bits, expected decode},
//               plus stall / stray-start and mid-frame reset sequences.
//               Honours COMPL1_NEGZERO_FIX_EN for the negative-zero rows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_compl1_deser_dec;

    localparam int WIDTH = 4;

    typedef struct {
        logic       cpl;
        logic [3:0] raw;    // bits as they appear on the line, bit 0 first
        logic [3:0] data;
        logic       sign;
        logic [2:0] mag;
        logic       nz;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    compl1_deser_dec_if #(.WIDTH(WIDTH)) bus ();

    compl1_deser_dec #(
        .WIDTH (WIDTH),
        .CNT_W (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    vec_t tbl [10];
    vec_t sb  [$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic cpl, input logic [3:0] raw, input logic [3:0] data,
                                input logic sign, input logic [2:0] mag, input logic nz);
        vec_t v;
        v.cpl = cpl; v.raw = raw; v.data = data; v.sign = sign; v.mag = mag; v.nz = nz;
        return v;
    endfunction

    // Drives one frame; lat = edges after the start edge until out_valid was first seen.
    task automatic send_frame(input logic cpl, input logic [3:0] raw, input int stall_at,
                              input int stall_len, input logic start_noise, output int lat);
        int n;
        n   = 0;
        lat = 0;
        bus.start     = 1'b1;
        bus.cpl_in    = cpl;
        bus.sin_valid = 1'b1;     // must be ignored in the start cycle
        bus.sin       = ~raw[0];
        tick;
        bus.start     = 1'b0;
        bus.sin_valid = 1'b0;
        chk("busy_after_start", bus.busy, 1);
        for (int i = 0; i < WIDTH; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    bus.sin_valid = 1'b0;
                    bus.sin       = 1'b1;
                    bus.start     = start_noise;
                    tick;
                    n++;
                    if (bus.out_valid && lat == 0) lat = n;
                end
                bus.start = 1'b0;
            end
            bus.sin       = raw[i];
            bus.sin_valid = 1'b1;
            tick;
            n++;
            if (bus.out_valid && lat == 0) lat = n;
        end
        bus.sin_valid = 1'b0;
        bus.sin       = 1'b0;
    endtask

    // Waits for a result, compares it against the scoreboard, holds, then handshakes.
    task automatic drain(input int hold, input logic start_noise);
        vec_t e;
        int   w;
        w = 0;
        while (!bus.out_valid && w < 20) begin
            tick;
            w++;
        end
        chk("out_valid_seen", bus.out_valid, 1);
        if (!bus.out_valid) return;
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
            return;
        end
        e = sb.pop_front();
        chk("data_out",    bus.data_out,    e.data);
        chk("sign_out",    bus.sign_out,    e.sign);
        chk("mag_out",     bus.mag_out,     e.mag);
        chk("negzero_out", bus.negzero_out, e.nz);
        bus.out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            bus.start = start_noise;
            tick;
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_data",  bus.data_out,  e.data);
            chk("hold_mag",   bus.mag_out,   e.mag);
        end
        bus.start     = start_noise;   // ignored in the handshake cycle too
        bus.out_ready = 1'b1;
        tick;
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        chk("valid_after_hs", bus.out_valid, 0);
        chk("busy_after_hs",  bus.busy,      0);
        chk("data_kept_idle", bus.data_out,  e.data);
    endtask

    initial begin
        int lat;

        tbl[0] = mk(1'b0, 4'b0101, 4'b0101, 1'b0, 3'b101, 1'b0);
        tbl[1] = mk(1'b1, 4'b1010, 4'b0101, 1'b0, 3'b101, 1'b0);
        tbl[2] = mk(1'b0, 4'b1010, 4'b1010, 1'b1, 3'b101, 1'b0);
`ifdef COMPL1_NEGZERO_FIX_EN
        tbl[3] = mk(1'b1, 4'b0000, 4'b0000, 1'b0, 3'b000, 1'b1);
        tbl[5] = mk(1'b0, 4'b1111, 4'b0000, 1'b0, 3'b000, 1'b1);
`else
        tbl[3] = mk(1'b1, 4'b0000, 4'b1111, 1'b1, 3'b000, 1'b1);
        tbl[5] = mk(1'b0, 4'b1111, 4'b1111, 1'b1, 3'b000, 1'b1);
`endif
        tbl[4] = mk(1'b0, 4'b0000, 4'b0000, 1'b0, 3'b000, 1'b0);
        tbl[6] = mk(1'b1, 4'b1100, 4'b0011, 1'b0, 3'b011, 1'b0);
        tbl[7] = mk(1'b1, 4'b0001, 4'b1110, 1'b1, 3'b001, 1'b0);
        tbl[8] = mk(1'b0, 4'b0111, 4'b0111, 1'b0, 3'b111, 1'b0);
        tbl[9] = mk(1'b0, 4'b1000, 4'b1000, 1'b1, 3'b111, 1'b0);

        bus.start = 0; bus.cpl_in = 0; bus.sin = 0; bus.sin_valid = 0; bus.out_ready = 0;
        rst = 1'b1;
        tick;
        tick;
        chk("rst_busy",    bus.busy,        0);
        chk("rst_valid",   bus.out_valid,   0);
        chk("rst_data",    bus.data_out,    0);
        chk("rst_sign",    bus.sign_out,    0);
        chk("rst_mag",     bus.mag_out,     0);
        chk("rst_negzero", bus.negzero_out, 0);
        rst = 1'b0;
        tick;

        // Table-driven frames, continuous sin_valid.
        for (int i = 0; i < 10; i++) begin
            sb.push_back(tbl[i]);
            send_frame(tbl[i].cpl, tbl[i].raw, -1, 0, 1'b0, lat);
            chk("latency", lat, WIDTH);
            drain(0, 1'b0);
        end

        // Stall of 2 cycles before bit 2, stray starts in SHIFT and DONE, 3-cycle backpressure.
        sb.push_back(mk(1'b0, 4'b0011, 4'b0011, 1'b0, 3'b011, 1'b0));
        send_frame(1'b0, 4'b0011, 2, 2, 1'b1, lat);
        chk("latency_stall", lat, WIDTH + 2);
        drain(3, 1'b1);
        tick;
        chk("idle_after_stray_start", bus.busy, 0);

        // Reset after two accepted bits aborts the frame.
        bus.start = 1'b1; bus.cpl_in = 1'b1;
        tick;
        bus.start = 1'b0;
        bus.sin_valid = 1'b1; bus.sin = 1'b1;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        bus.sin_valid = 1'b0;
        chk("abort_busy",    bus.busy,        0);
        chk("abort_valid",   bus.out_valid,   0);
        chk("abort_data",    bus.data_out,    0);
        chk("abort_sign",    bus.sign_out,    0);
        chk("abort_mag",     bus.mag_out,     0);
        chk("abort_negzero", bus.negzero_out, 0);
        tick;
        tick;
        chk("abort_no_output", bus.out_valid, 0);

        sb.push_back(mk(1'b0, 4'b0110, 4'b0110, 1'b0, 3'b110, 1'b0));
        send_frame(1'b0, 4'b0110, -1, 0, 1'b0, lat);
        chk("latency_after_rst", lat, WIDTH);
        drain(1, 1'b0);

        chk("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/compl1_deser_dec.md
Name: compl1_deser_dec

Overview:
- Receive-side counterpart of the team's 4-bit ones'-complement stage (conditional invert under a `cpl` flag).
- Takes a word shifted in serially, LSB first, together with the `cpl` flag it was coded with, and restores the original word.
- Also decodes the restored word as a signed ones'-complement value: sign, magnitude and negative-zero flag.
- Sits between a serial link and the datapath, with a valid/ready output handshake.

Parameters:
- WIDTH, 4: word width in bits; legal range 2..16.
- CNT_W, 4: width of the bit counter; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  frame start; sampled only in IDLE.
- cpl_in  input  1  complement flag of the incoming frame; captured when start is accepted.
- sin  input  1  serial data bit, LSB first.
- sin_valid  input  1  sin holds a valid bit this cycle.
- out_ready  input  1  consumer accepts the result.
- busy  output  1  frame in progress (SHIFT or DONE).
- out_valid  output  1  result valid; held until accepted.
- data_out  output  WIDTH  restored word = received bits XOR {WIDTH{cpl}}.
- sign_out  output  1  data_out[WIDTH-1].
- mag_out  output  WIDTH-1  magnitude of data_out read as ones'-complement.
- negzero_out  output  1  data_out is all ones (negative zero).

Behaviour:
- All outputs are registered.
- Reset:
  - Synchronous: rst=1 at an edge forces state IDLE, counter 0, shift register 0, cpl_r 0.
  - All outputs become 0 after that edge.
  - rst overrides every other input.
  - rst mid-frame aborts the frame; nothing is ever output for it.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, out_valid=0.
  - start=1 captures cpl_r<=cpl_in, clears the counter and shift register, then moves to SHIFT.
  - sin/sin_valid are ignored in IDLE, including in the start cycle.
- SHIFT:
  - busy=1.
  - Each cycle with sin_valid=1: shift register shifts right, sin enters at bit WIDTH-1, counter increments.
  - sin_valid=0 is a stall: no change.
  - start is ignored.
  - When the bit accepted is number WIDTH (counter == WIDTH-1 at that edge), go to DONE and load the outputs in the same edge.
- Output computation:
  - data_out = sreg_final XOR {WIDTH{cpl_r}}.
  - sign_out = data_out[WIDTH-1].
  - mag_out = sign_out ? ~data_out[WIDTH-2:0] : data_out[WIDTH-2:0].
  - negzero_out = &data_out.
- DONE:
  - out_valid=1, busy=1.
  - Outputs are stable while out_valid=1 and out_ready=0.
  - out_valid & out_ready at an edge leads to IDLE: out_valid=0 and busy=0 next cycle.
  - data_out, mag_out, sign_out and negzero_out keep their last values in IDLE.
  - start is ignored in DONE, even in the handshake cycle. The earliest new start is the first IDLE cycle.
- Latency:
  - start accepted at edge T.
  - With continuous sin_valid, bits are taken at edges T+1..T+WIDTH.
  - out_valid=1 from cycle T+WIDTH (visible after edge T+WIDTH).
  - Minimum frame turnaround is WIDTH+2 cycles.
- Width rule: the counter saturates logic only at WIDTH-1; no wrap is reachable.

Optional Feature:
- Macro: COMPL1_NEGZERO_FIX_EN.
- Defined: negative zero is canonicalised to +0.
  - When the restored word is all ones: data_out=0, sign_out=0, mag_out=0, negzero_out=1.
  - negzero_out records that the fix was applied.
- Undefined:
  - data_out is left as all ones, sign_out=1, mag_out=0, negzero_out=1.

Test Plan:
- WIDTH=4, cpl_in=0, start, then sin 1,0,1,0 continuous:
  - out_valid rises after edge T+4.
  - data_out=0101, sign_out=0, mag_out=101, negzero_out=0.
- cpl_in=1, sin 0,1,0,1 (word 1010 sent):
  - data_out=0101, mag_out=101, sign_out=0.
- cpl_in=0, sin 0,1,0,1:
  - data_out=1010, sign_out=1, mag_out=101 (value -5).
- cpl_in=1, sin 0,0,0,0:
  - Macro undefined: data_out=1111, sign_out=1, mag_out=000, negzero_out=1.
  - Macro defined: data_out=0000, sign_out=0, negzero_out=1.
- Stalls, cpl_in=0, word 0011 with sin_valid low for 2 cycles between bits 2 and 3, out_ready low 3 cycles:
  - out_valid rises 2 cycles later than the unstalled case.
  - Outputs hold for the 3 cycles.
  - A start pulse during SHIFT/DONE is ignored.
  - Result data_out=0011.
- rst=1 after 2 bits accepted:
  - Next cycle busy=0, out_valid=0, all outputs 0.
  - A new frame 0110 with cpl_in=0 then decodes to data_out=0110.
